// File: rtl/out_port_hs_pkg.sv
// Shared types and constants for the out_port_hs output port.
package out_port_hs_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;
    // Pointer width is tied to the FIFO depth; DEPTH must stay a power of two.
    localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESENT  = 2'd1,
        WAIT_REL = 2'd2
    } hs_state_e;

endpackage

// File: rtl/out_port_fifo.sv
// Synchronous FIFO between CPU writes and the device handshake.
// Full/Empty are registered and derived from the next occupancy.
module out_port_fifo
    import out_port_hs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PTR_W  = PTR_W_DEF
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok;
    logic              pop_ok;

    // A write against a full FIFO is dropped even if a pop happens on the same edge.
    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/out_port_hs.sv
// CPU-written output port: FIFO plus a 4-phase valid/ack handshake to the device.
// Optional macro OUT_PORT_OVERFLOW_EN adds a sticky Overflow flag for dropped writes.
module out_port_hs
    import out_port_hs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              OutPortin,
    output logic [DATA_W-1:0] DevData,
    output logic              DevValid,
    input  logic              DevAck,
    output logic              Full,
    output logic              Empty,
    output logic [PTR_W:0]    Count
`ifdef OUT_PORT_OVERFLOW_EN
    ,
    output logic              Overflow
`endif
);

    hs_state_e         state_q, state_d;
    logic [DATA_W-1:0] dev_data_q, dev_data_d;
    logic              dev_valid_q, dev_valid_d;
    logic              pop;
    logic [DATA_W-1:0] fifo_head;

    out_port_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk   (Clock),
        .clear (Clear),
        .push  (OutPortin),
        .pop   (pop),
        .wdata (BusMuxOut),
        .head  (fifo_head),
        .count (Count),
        .full  (Full),
        .empty (Empty)
    );

    // DevData is loaded only when a word is presented, so it stays stable through the ack.
    always_comb begin
        state_d     = state_q;
        dev_data_d  = dev_data_q;
        dev_valid_d = dev_valid_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!Empty) begin
                    dev_data_d  = fifo_head;
                    dev_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (DevAck) begin
                    dev_valid_d = 1'b0;
                    pop         = 1'b1;
                    state_d     = WAIT_REL;
                end
            end
            WAIT_REL: begin
                dev_valid_d = 1'b0;
                if (!DevAck) begin
                    state_d = IDLE;
                end
            end
            default: begin
                dev_valid_d = 1'b0;
                state_d     = WAIT_REL;
            end
        endcase
    end

    // Reset lands in WAIT_REL so a stale ack must drop before anything is presented.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q     <= WAIT_REL;
            dev_data_q  <= '0;
            dev_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dev_data_q  <= dev_data_d;
            dev_valid_q <= dev_valid_d;
        end
    end

    assign DevData  = dev_data_q;
    assign DevValid = dev_valid_q;

`ifdef OUT_PORT_OVERFLOW_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (OutPortin & Full);
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign Overflow = overflow_q;
`endif

endmodule

// File: tb/tb_out_port_hs.sv
// Self-checking bench for out_port_hs: vector table, directed corner sequences and
// randomized traffic checked against a queue-based behavioural model.
module tb_out_port_hs;

    localparam int DEPTH = 4;

    logic        Clock;
    logic        Clear;
    logic [31:0] BusMuxOut;
    logic        OutPortin;
    logic [31:0] DevData;
    logic        DevValid;
    logic        DevAck;
    logic        Full;
    logic        Empty;
    logic [2:0]  Count;
`ifdef OUT_PORT_OVERFLOW_EN
    logic        Overflow;
`endif

    out_port_hs dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .BusMuxOut (BusMuxOut),
        .OutPortin (OutPortin),
        .DevData   (DevData),
        .DevValid  (DevValid),
        .DevAck    (DevAck),
        .Full      (Full),
        .Empty     (Empty),
        .Count     (Count)
`ifdef OUT_PORT_OVERFLOW_EN
        ,
        .Overflow  (Overflow)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model: the FIFO is a queue, the handshake is "presenting" / "awaiting release".
    logic [31:0] mq[$];
    logic [31:0] rxQ[$];
    bit          mValid = 1'b0;
    bit          mRel   = 1'b1;
    logic [31:0] mData  = '0;
    bit          mOvf   = 1'b0;

    typedef struct {
        logic        clr;
        logic        psh;
        logic [31:0] d;
        logic        ack;
        logic        eValid;
        logic [31:0] eData;
        logic [2:0]  eCount;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic modelStep(input logic clr, input logic psh, input logic [31:0] d,
                             input logic ack);
        int  sz;
        bit  popNow;
        if (clr) begin
            mq.delete();
            mValid = 1'b0;
            mRel   = 1'b1;
            mData  = '0;
            mOvf   = 1'b0;
            return;
        end
        sz     = mq.size();
        popNow = 1'b0;
        if (psh && sz == DEPTH) mOvf = 1'b1;
        if (mValid) begin
            if (ack) begin
                mValid = 1'b0;
                mRel   = 1'b1;
                popNow = 1'b1;
            end
        end else if (mRel) begin
            if (!ack) mRel = 1'b0;
        end else if (sz > 0) begin
            mValid = 1'b1;
            mData  = mq[0];
        end
        if (popNow) void'(mq.pop_front());
        if (psh && sz < DEPTH) mq.push_back(d);
    endtask

    task automatic checkOutput();
        check("DevValid", {31'b0, DevValid}, {31'b0, mValid});
        check("DevData", DevData, mData);
        check("Count", {29'b0, Count}, 32'(mq.size()));
        check("Full", {31'b0, Full}, {31'b0, mq.size() == DEPTH});
        check("Empty", {31'b0, Empty}, {31'b0, mq.size() == 0});
`ifdef OUT_PORT_OVERFLOW_EN
        check("Overflow", {31'b0, Overflow}, {31'b0, mOvf});
`endif
    endtask

    // Drive one edge's worth of inputs (called at a negedge), then check after the edge.
    task automatic applyStimulus(input logic clr, input logic psh, input logic [31:0] d,
                                 input logic ack);
        if (!clr && DevValid && ack) rxQ.push_back(DevData);
        Clear     = clr;
        OutPortin = psh;
        BusMuxOut = d;
        DevAck    = ack;
        modelStep(clr, psh, d, ack);
        @(posedge Clock);
        @(negedge Clock);
        checkOutput();
    endtask

    task automatic drainAll(input int maxCycles);
        int cyc = 0;
        while ((mq.size() > 0 || mValid) && cyc < maxCycles) begin
            applyStimulus(1'b0, 1'b0, 32'h0, DevValid);
            cyc++;
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        check("drainBound", 32'(cyc < maxCycles), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        Clear     = 1'b1;
        OutPortin = 1'b0;
        BusMuxOut = '0;
        DevAck    = 1'b0;
        @(negedge Clock);

        // Reset with stale ack, then a single-word handshake.
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_00AA, 1'b1, 1'b0, 32'h0,         3'd1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd1};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         3'd1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         3'd1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_00AA, 3'd1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_00AA, 3'd0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_00AA, 3'd0};
        vecs[8]  = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_00AA, 3'd1};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 3'd1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 3'd1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h1234_5678, 3'd0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h1234_5678, 3'd0};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].clr, vecs[i].psh, vecs[i].d, vecs[i].ack);
            check($sformatf("tbl%0d.valid", i), {31'b0, DevValid}, {31'b0, vecs[i].eValid});
            check($sformatf("tbl%0d.data", i), DevData, vecs[i].eData);
            check($sformatf("tbl%0d.count", i), {29'b0, Count}, {29'b0, vecs[i].eCount});
        end

        // Fill to capacity, overflow with word 5, then drain in order.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        rxQ.delete();
        for (int k = 1; k <= 5; k++) applyStimulus(1'b0, 1'b1, 32'(k), 1'b0);
        check("fill.count", {29'b0, Count}, 32'd4);
        check("fill.full", {31'b0, Full}, 32'd1);
`ifdef OUT_PORT_OVERFLOW_EN
        check("fill.overflow", {31'b0, Overflow}, 32'd1);
`endif
        drainAll(60);
        check("fill.rxCount", 32'(rxQ.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fill.rx%0d", k), (k < rxQ.size()) ? rxQ[k] : 32'hFFFF_FFFF,
                  32'(k + 1));
        end
        check("fill.empty", {31'b0, Empty}, 32'd1);
`ifdef OUT_PORT_OVERFLOW_EN
        check("fill.overflowSticky", {31'b0, Overflow}, 32'd1);
`endif

        // Push and pop on the same edge with two words queued.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        rxQ.delete();
        applyStimulus(1'b0, 1'b1, 32'h0000_0111, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0222, 1'b0);
        check("pp.valid", {31'b0, DevValid}, 32'd1);
        check("pp.countBefore", {29'b0, Count}, 32'd2);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        check("pp.countAfter", {29'b0, Count}, 32'd2);
        drainAll(60);
        check("pp.rxCount", 32'(rxQ.size()), 32'd3);
        check("pp.last", (rxQ.size() == 3) ? rxQ[2] : 32'h0, 32'hDEAD_BEEF);

        // Stream ten words through an immediate-ack device to exercise pointer wrap.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        rxQ.delete();
        begin
            int nxt = 0;
            int cyc = 0;
            while (rxQ.size() < 10 && cyc < 300) begin
                logic psh;
                psh = (nxt < 10) && (mq.size() < DEPTH);
                applyStimulus(1'b0, psh, 32'(nxt), DevValid);
                if (psh) nxt++;
                cyc++;
            end
        end
        check("wrap.rxCount", 32'(rxQ.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("wrap.rx%0d", k), (k < rxQ.size()) ? rxQ[k] : 32'hFFFF_FFFF,
                  32'(k));
        end

        // Clear while a word is presented and two more are queued.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0A01, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0A02, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0A03, 1'b0);
        check("mid.validBefore", {31'b0, DevValid}, 32'd1);
        check("mid.countBefore", {29'b0, Count}, 32'd3);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        check("mid.valid", {31'b0, DevValid}, 32'd0);
        check("mid.count", {29'b0, Count}, 32'd0);
        check("mid.empty", {31'b0, Empty}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            check("mid.noStale", {31'b0, DevValid}, 32'd0);
        end

        // Randomized traffic against the model, with occasional clears.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 600; c++) begin
            logic clr, psh, ack;
            clr = ($urandom % 97) == 0;
            psh = $urandom % 2;
            ack = (($urandom % 3) == 0) ? ~DevAck : DevAck;
            applyStimulus(clr, psh, $urandom, ack);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
